// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 responder backed by an internal word array.
// Independent read and write FSMs, one outstanding burst per direction,
// FIXED and INCR (WRAP treated as INCR) bursts of up to 256 full-width beats.
// Ports:
//   clk_i, rst_i             clock, asynchronous active-high reset
//   ar*_i / arready_o        read address channel (cache/prot/lock ignored)
//   r*_o / rready_i          read data channel
//   aw*_i / awready_o        write address channel (cache/prot/lock ignored)
//   w*_i / wready_o          write data channel
//   b*_o / bready_i          write response channel
module axi_sram_slave #(
  parameter int ADDR_WIDTH     = 32,
  parameter int AXI_DATA_WIDTH = 128,
  parameter int ID_WIDTH       = 4,
  parameter int MEM_DEPTH      = 4096
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        arvalid_i,
  output logic                        arready_o,
  input  logic [ADDR_WIDTH-1:0]       araddr_i,
  input  logic [7:0]                  arlen_i,
  input  logic [2:0]                  arsize_i,
  input  logic [1:0]                  arburst_i,
  input  logic [ID_WIDTH-1:0]         arid_i,
  input  logic [3:0]                  arcache_i,
  input  logic [2:0]                  arprot_i,
  input  logic [1:0]                  arlock_i,
  output logic                        rvalid_o,
  input  logic                        rready_i,
  output logic [AXI_DATA_WIDTH-1:0]   rdata_o,
  output logic [1:0]                  rresp_o,
  output logic                        rlast_o,
  output logic [ID_WIDTH-1:0]         rid_o,
  input  logic                        awvalid_i,
  output logic                        awready_o,
  input  logic [ADDR_WIDTH-1:0]       awaddr_i,
  input  logic [7:0]                  awlen_i,
  input  logic [2:0]                  awsize_i,
  input  logic [1:0]                  awburst_i,
  input  logic [ID_WIDTH-1:0]         awid_i,
  input  logic [3:0]                  awcache_i,
  input  logic [2:0]                  awprot_i,
  input  logic [1:0]                  awlock_i,
  input  logic                        wvalid_i,
  output logic                        wready_o,
  input  logic [AXI_DATA_WIDTH-1:0]   wdata_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] wstrb_i,
  input  logic                        wlast_i,
  output logic                        bvalid_o,
  input  logic                        bready_i,
  output logic [1:0]                  bresp_o,
  output logic [ID_WIDTH-1:0]         bid_o
);
  localparam int B  = AXI_DATA_WIDTH / 8;
  localparam int LB = $clog2(B);
  localparam int IW = $clog2(MEM_DEPTH);
  localparam logic [2:0] FULL_SIZE = 3'(LB);
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

  logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Any address bit above the array span marks the whole burst out of range;
  // INCR wraps inside the array, so the flag never changes mid-burst.
  logic ar_oor, aw_oor;
  assign ar_oor = (araddr_i >> (LB + IW)) != '0;
  assign aw_oor = (awaddr_i >> (LB + IW)) != '0;

  logic unused_ok;
  assign unused_ok = ^{arcache_i, arprot_i, arlock_i, awcache_i, awprot_i, awlock_i,
                       araddr_i[LB-1:0], awaddr_i[LB-1:0]};

  // ---------------- read FSM ----------------
  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  r_state_e              r_state_q, r_state_d;
  logic [IW-1:0]         r_idx_q, r_idx_d;
  logic [7:0]            r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
  logic                  r_fixed_q, r_fixed_d, r_err_q, r_err_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state_q <= R_IDLE; r_idx_q <= '0; r_len_q <= '0; r_cnt_q <= '0;
      r_id_q <= '0; r_fixed_q <= 1'b0; r_err_q <= 1'b0;
    end else begin
      r_state_q <= r_state_d; r_idx_q <= r_idx_d; r_len_q <= r_len_d; r_cnt_q <= r_cnt_d;
      r_id_q <= r_id_d; r_fixed_q <= r_fixed_d; r_err_q <= r_err_d;
    end
  end

  always_comb begin
    r_state_d = r_state_q; r_idx_d = r_idx_q; r_len_d = r_len_q; r_cnt_d = r_cnt_q;
    r_id_d = r_id_q; r_fixed_d = r_fixed_q; r_err_d = r_err_q;
    arready_o = 1'b0; rvalid_o = 1'b0; rdata_o = '0; rresp_o = OKAY; rlast_o = 1'b0; rid_o = '0;
    case (r_state_q)
      R_IDLE: begin
        // state is already IDLE under reset; gating keeps arready low there too
        arready_o = !rst_i;
        if (arvalid_i && !rst_i) begin
          r_idx_d   = araddr_i[LB+IW-1:LB];
          r_len_d   = arlen_i;
          r_cnt_d   = '0;
          r_id_d    = arid_i;
          r_fixed_d = (arburst_i == 2'b00);
          r_err_d   = ar_oor || (arsize_i != FULL_SIZE);
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        rvalid_o = 1'b1;
        rlast_o  = (r_cnt_q == r_len_q);
        rid_o    = r_id_q;
        rresp_o  = r_err_q ? SLVERR : OKAY;
        rdata_o  = r_err_q ? '0 : mem[r_idx_q];
        if (rready_i) begin
          if (r_cnt_q == r_len_q) r_state_d = R_IDLE;
          else begin
            r_cnt_d = r_cnt_q + 8'd1;
            if (!r_fixed_q) r_idx_d = r_idx_q + 1'b1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // ---------------- write FSM ----------------
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  w_state_e              w_state_q, w_state_d;
  logic [IW-1:0]         w_idx_q, w_idx_d;
  logic [7:0]            w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic [ID_WIDTH-1:0]   w_id_q, w_id_d;
  logic                  w_fixed_q, w_fixed_d, w_oor_q, w_oor_d, w_err_q, w_err_d;
  logic                  mem_we;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_state_q <= W_IDLE; w_idx_q <= '0; w_len_q <= '0; w_cnt_q <= '0; w_id_q <= '0;
      w_fixed_q <= 1'b0; w_oor_q <= 1'b0; w_err_q <= 1'b0;
    end else begin
      w_state_q <= w_state_d; w_idx_q <= w_idx_d; w_len_q <= w_len_d; w_cnt_q <= w_cnt_d;
      w_id_q <= w_id_d; w_fixed_q <= w_fixed_d; w_oor_q <= w_oor_d; w_err_q <= w_err_d;
    end
  end

  always_comb begin
    w_state_d = w_state_q; w_idx_d = w_idx_q; w_len_d = w_len_q; w_cnt_d = w_cnt_q;
    w_id_d = w_id_q; w_fixed_d = w_fixed_q; w_oor_d = w_oor_q; w_err_d = w_err_q;
    awready_o = 1'b0; wready_o = 1'b0; bvalid_o = 1'b0; bresp_o = OKAY; bid_o = '0;
    mem_we = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        awready_o = !rst_i;
        if (awvalid_i && !rst_i) begin
          w_idx_d   = awaddr_i[LB+IW-1:LB];
          w_len_d   = awlen_i;
          w_cnt_d   = '0;
          w_id_d    = awid_i;
          w_fixed_d = (awburst_i == 2'b00);
          w_oor_d   = aw_oor;
          w_err_d   = (awsize_i != FULL_SIZE);
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        wready_o = 1'b1;
        if (wvalid_i) begin
          mem_we = !w_oor_q;
          if (w_oor_q) w_err_d = 1'b1;
          if (!w_fixed_q) w_idx_d = w_idx_q + 1'b1;
          if (wlast_i) begin
            if (w_cnt_q != w_len_q) w_err_d = 1'b1;
            w_state_d = W_RESP;
          end else if (w_cnt_q == w_len_q) begin
            // overlong burst: keep absorbing beats until wlast, counter saturates
            w_err_d = 1'b1;
          end else begin
            w_cnt_d = w_cnt_q + 8'd1;
          end
        end
      end
      W_RESP: begin
        bvalid_o = 1'b1;
        bid_o    = w_id_q;
        bresp_o  = w_err_q ? SLVERR : OKAY;
        if (bready_i) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Byte-masked write; contents deliberately not reset. A same-cycle read of
  // this word sees the old value since the read path is combinational.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < B; b++)
        if (wstrb_i[b]) mem[w_idx_q][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
module tb_axi_sram_slave;
  localparam int AW = 32, DW = 128, IDW = 4, DEPTH = 4096, BB = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            arvalid = 0, arready, rvalid, rready = 0, rlast;
  logic [AW-1:0]   araddr = '0;
  logic [7:0]      arlen = '0;
  logic [2:0]      arsize = 3'd4;
  logic [1:0]      arburst = 2'b01, rresp;
  logic [IDW-1:0]  arid = '0, rid;
  logic [DW-1:0]   rdata;
  logic            awvalid = 0, awready, wvalid = 0, wready, wlast = 0, bvalid, bready = 0;
  logic [AW-1:0]   awaddr = '0;
  logic [7:0]      awlen = '0;
  logic [2:0]      awsize = 3'd4;
  logic [1:0]      awburst = 2'b01, bresp;
  logic [IDW-1:0]  awid = '0, bid;
  logic [DW-1:0]   wdata = '0;
  logic [BB-1:0]   wstrb = '0;

  axi_sram_slave #(.ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .ID_WIDTH(IDW), .MEM_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .arvalid_i(arvalid), .arready_o(arready), .araddr_i(araddr), .arlen_i(arlen),
    .arsize_i(arsize), .arburst_i(arburst), .arid_i(arid), .arcache_i(4'h0),
    .arprot_i(3'h0), .arlock_i(2'h0),
    .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata), .rresp_o(rresp),
    .rlast_o(rlast), .rid_o(rid),
    .awvalid_i(awvalid), .awready_o(awready), .awaddr_i(awaddr), .awlen_i(awlen),
    .awsize_i(awsize), .awburst_i(awburst), .awid_i(awid), .awcache_i(4'h0),
    .awprot_i(3'h0), .awlock_i(2'h0),
    .wvalid_i(wvalid), .wready_o(wready), .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast),
    .bvalid_o(bvalid), .bready_i(bready), .bresp_o(bresp), .bid_o(bid)
  );

  int vec = 0, miscmp = 0;

  logic [DW-1:0]  rd_data [256];
  logic [1:0]     rd_resp [256];
  logic           rd_last [256];
  logic [IDW-1:0] rd_id   [256];
  int rd_n, rd_first, rd_stalls, rd_hold_bad;

  task automatic do_read(input logic [AW-1:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [IDW-1:0] id, input bit toggle);
    int n;
    bit done, held;
    logic [DW-1:0] hd;
    logic hl;
    logic [1:0] hr;
    rd_n = 0; rd_first = -1; rd_stalls = 0; rd_hold_bad = 0;
    araddr = addr; arlen = len; arsize = size; arburst = burst; arid = id; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(posedge clk); #1; n++; end
    if (!arready) begin
      arvalid = 1'b0; vec++; miscmp++;
      $display("FAIL ar_handshake: arready=%0b after %0d cycles, required 1", arready, n);
      return;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    done = 0; held = 0; n = 0; hd = '0; hl = 0; hr = '0;
    while (!done && n < 1000) begin
      rready = toggle ? (n % 2 == 0) : 1'b1;
      if (held && (rdata !== hd || rlast !== hl || rresp !== hr)) rd_hold_bad++;
      held = 0;
      if (rvalid && rready) begin
        if (rd_first < 0) rd_first = n;
        if (rd_n < 256) begin
          rd_data[rd_n] = rdata; rd_resp[rd_n] = rresp; rd_last[rd_n] = rlast; rd_id[rd_n] = rid;
        end
        rd_n++;
        if (rlast) done = 1;
      end else if (rvalid) begin
        hd = rdata; hl = rlast; hr = rresp; held = 1; rd_stalls++;
      end
      @(posedge clk); #1;
      n++;
    end
    rready = 1'b0;
    if (!done) begin
      vec++; miscmp++;
      $display("FAIL r_burst_end: no rlast after %0d cycles, beats=%0d", n, rd_n);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [7:0] len, input int nbeats,
                          input logic [2:0] size, input logic [1:0] burst, input logic [IDW-1:0] id,
                          input logic [DW-1:0] base, input logic [BB-1:0] strb,
                          output logic [1:0] resp, output logic [IDW-1:0] rbid);
    int n;
    resp = 2'bxx; rbid = 'x;
    awaddr = addr; awlen = len; awsize = size; awburst = burst; awid = id; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(posedge clk); #1; n++; end
    if (!awready) begin
      awvalid = 1'b0; vec++; miscmp++;
      $display("FAIL aw_handshake: awready=%0b after %0d cycles, required 1", awready, n);
      return;
    end
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      wvalid = 1'b1; wdata = base + DW'(i); wstrb = strb; wlast = (i == nbeats - 1);
      n = 0;
      while (!wready && n < 50) begin @(posedge clk); #1; n++; end
      if (!wready) begin
        wvalid = 1'b0; wlast = 1'b0; vec++; miscmp++;
        $display("FAIL w_handshake: beat %0d wready=%0b, required 1", i, wready);
        return;
      end
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin @(posedge clk); #1; n++; end
    if (!bvalid) begin
      vec++; miscmp++;
      $display("FAIL b_wait: bvalid=%0b after %0d cycles, required 1", bvalid, n);
      return;
    end
    resp = bresp; rbid = bid; bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vec++;
    if ({arready, awready, rvalid, wready, bvalid, rlast, rresp, bresp} !== 10'b0 || rdata !== '0) begin
      miscmp++;
      $display("FAIL reset_outputs: ar=%0b aw=%0b rv=%0b wr=%0b bv=%0b rdata=%h, required all 0",
               arready, awready, rvalid, wready, bvalid, rdata);
    end
    rst = 1'b0;
    #1;
    vec++;
    if (arready !== 1'b1 || awready !== 1'b1) begin
      miscmp++;
      $display("FAIL reset_release_ready: arready=%0b awready=%0b, required 1 1", arready, awready);
    end
    wvalid = 1'b1; wstrb = '1; wdata = '1;
    @(posedge clk); #1;
    vec++;
    if (wready !== 1'b0) begin
      miscmp++;
      $display("FAIL w_before_aw: wready=%0b, required 0", wready);
    end
    wvalid = 1'b0;
  endtask

  task automatic test_single_beat();
    logic [1:0] r; logic [IDW-1:0] b;
    logic [DW-1:0] d = 128'h0123456789ABCDEF0123456789ABCDEF;
    do_write(32'h100, 8'd0, 1, 3'd4, 2'b01, 4'd3, d, '1, r, b);
    vec++;
    if (r !== 2'b00 || b !== 4'd3) begin
      miscmp++; $display("FAIL single_b: bresp=%b bid=%0d, required 00 3", r, b);
    end
    do_read(32'h100, 8'd0, 3'd4, 2'b01, 4'd3, 0);
    vec++;
    if (rd_n !== 1 || rd_first !== 0 || rd_data[0] !== d || rd_last[0] !== 1'b1 ||
        rd_id[0] !== 4'd3 || rd_resp[0] !== 2'b00) begin
      miscmp++;
      $display("FAIL single_r: n=%0d first=%0d data=%h last=%0b id=%0d resp=%b, required 1 0 %h 1 3 00",
               rd_n, rd_first, rd_data[0], rd_last[0], rd_id[0], rd_resp[0], d);
    end
  endtask

  task automatic test_incr_stall();
    logic [1:0] r; logic [IDW-1:0] b;
    do_write(32'h0, 8'd7, 8, 3'd4, 2'b01, 4'd1, '0, '1, r, b);
    vec++;
    if (r !== 2'b00 || b !== 4'd1) begin
      miscmp++; $display("FAIL preload_b: bresp=%b bid=%0d, required 00 1", r, b);
    end
    do_read(32'h0, 8'd7, 3'd4, 2'b01, 4'd5, 1);
    vec++;
    if (rd_n !== 8) begin
      miscmp++; $display("FAIL incr_count: beats=%0d, required 8", rd_n);
    end
    for (int i = 0; i < 8; i++) begin
      vec++;
      if (rd_data[i] !== DW'(i) || rd_last[i] !== (i == 7) || rd_id[i] !== 4'd5 || rd_resp[i] !== 2'b00) begin
        miscmp++;
        $display("FAIL incr_beat%0d: data=%h last=%0b id=%0d resp=%b, required %0d %0b 5 00",
                 i, rd_data[i], rd_last[i], rd_id[i], rd_resp[i], i, (i == 7));
      end
    end
    vec++;
    if (rd_stalls !== 7 || rd_hold_bad !== 0) begin
      miscmp++; $display("FAIL incr_hold: stalls=%0d unstable=%0d, required 7 0", rd_stalls, rd_hold_bad);
    end
    do_read(32'h10, 8'd2, 3'd4, 2'b00, 4'd2, 0);
    vec++;
    if (rd_n !== 3 || rd_data[0] !== DW'(1) || rd_data[1] !== DW'(1) || rd_data[2] !== DW'(1)) begin
      miscmp++;
      $display("FAIL fixed_read: n=%0d d0=%h d1=%h d2=%h, required 3 1 1 1", rd_n, rd_data[0], rd_data[1], rd_data[2]);
    end
  endtask

  task automatic test_strobe();
    logic [1:0] r; logic [IDW-1:0] b;
    logic [DW-1:0] exp = {{(DW-8){1'b1}}, 8'hAA};
    do_write(32'h200, 8'd0, 1, 3'd4, 2'b01, 4'd0, '1, '1, r, b);
    do_write(32'h200, 8'd0, 1, 3'd4, 2'b01, 4'd0, DW'(8'hAA), BB'(1), r, b);
    do_read(32'h200, 8'd0, 3'd4, 2'b01, 4'd0, 0);
    vec++;
    if (rd_data[0] !== exp) begin
      miscmp++; $display("FAIL strobe: rdata=%h, required %h", rd_data[0], exp);
    end
  endtask

  task automatic test_errors();
    logic [1:0] r; logic [IDW-1:0] b;
    do_read(AW'(DEPTH * BB), 8'd0, 3'd4, 2'b01, 4'd6, 0);
    vec++;
    if (rd_resp[0] !== 2'b10 || rd_data[0] !== '0 || rd_last[0] !== 1'b1) begin
      miscmp++; $display("FAIL r_oor: resp=%b data=%h last=%0b, required 10 0 1", rd_resp[0], rd_data[0], rd_last[0]);
    end
    do_read(32'h0, 8'd1, 3'd3, 2'b01, 4'd6, 0);
    vec++;
    if (rd_n !== 2 || rd_resp[0] !== 2'b10 || rd_resp[1] !== 2'b10 || rd_data[1] !== '0) begin
      miscmp++; $display("FAIL r_size: n=%0d resp0=%b resp1=%b data1=%h, required 2 10 10 0",
                         rd_n, rd_resp[0], rd_resp[1], rd_data[1]);
    end
    do_write(32'h300, 8'd3, 3, 3'd4, 2'b01, 4'd7, '0, '1, r, b);
    vec++;
    if (r !== 2'b10 || b !== 4'd7) begin
      miscmp++; $display("FAIL w_early_last: bresp=%b bid=%0d, required 10 7", r, b);
    end
    do_write(32'h300, 8'd1, 3, 3'd4, 2'b01, 4'd2, '0, '1, r, b);
    vec++;
    if (r !== 2'b10) begin
      miscmp++; $display("FAIL w_late_last: bresp=%b, required 10", r);
    end
    do_write(AW'(DEPTH * BB), 8'd0, 1, 3'd4, 2'b01, 4'd1, '0, '1, r, b);
    vec++;
    if (r !== 2'b10) begin
      miscmp++; $display("FAIL w_oor: bresp=%b, required 10", r);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] r; logic [IDW-1:0] b;
    fork
      do_write(32'h400, 8'd3, 4, 3'd4, 2'b01, 4'd9, DW'(16'h100), '1, r, b);
      do_read(32'h0, 8'd3, 3'd4, 2'b01, 4'd4, 0);
    join
    vec++;
    if (r !== 2'b00 || b !== 4'd9) begin
      miscmp++; $display("FAIL concur_b: bresp=%b bid=%0d, required 00 9", r, b);
    end
    vec++;
    if (rd_n !== 4 || rd_data[0] !== DW'(0) || rd_data[3] !== DW'(3) || rd_resp[3] !== 2'b00) begin
      miscmp++; $display("FAIL concur_r: n=%0d d0=%h d3=%h resp=%b, required 4 0 3 00",
                         rd_n, rd_data[0], rd_data[3], rd_resp[3]);
    end
    do_read(32'h400, 8'd3, 3'd4, 2'b01, 4'd4, 0);
    vec++;
    if (rd_data[0] !== DW'(16'h100) || rd_data[3] !== DW'(16'h103)) begin
      miscmp++; $display("FAIL concur_readback: d0=%h d3=%h, required 100 103", rd_data[0], rd_data[3]);
    end
  endtask

  task automatic test_reset_mid_read();
    araddr = 32'h0; arlen = 8'd7; arsize = 3'd4; arburst = 2'b01; arid = 4'd1;
    arvalid = 1'b1; rready = 1'b0;
    @(posedge clk); #1;
    arvalid = 1'b0;
    vec++;
    if (rvalid !== 1'b1) begin
      miscmp++; $display("FAIL mid_start: rvalid=%0b, required 1", rvalid);
    end
    #2 rst = 1'b1;
    #1;
    vec++;
    if (rvalid !== 1'b0 || arready !== 1'b0) begin
      miscmp++; $display("FAIL mid_reset: rvalid=%0b arready=%0b, required 0 0", rvalid, arready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    vec++;
    if (arready !== 1'b1 || rvalid !== 1'b0) begin
      miscmp++; $display("FAIL post_reset: arready=%0b rvalid=%0b, required 1 0", arready, rvalid);
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_incr_stall();
    test_strobe();
    test_errors();
    test_back_to_back();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end
endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI4 slave (responder) backed by an internal synchronous-write word array.
- Serves the master-side AXI traffic of the cache/bridge in simulation and on-chip scratch configurations.
- Independent read and write FSMs, one outstanding transaction per direction.
- Supports FIXED and INCR bursts up to 256 beats at the full data width.

Parameters:
ADDR_WIDTH, 32, AXI address width
AXI_DATA_WIDTH, 128, data bus width in bits; byte count B = AXI_DATA_WIDTH/8
ID_WIDTH, 4, width of arid/awid/rid/bid
MEM_DEPTH, 4096, number of AXI_DATA_WIDTH words; power of two

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous active-high reset
arvalid/arready  in/out  1/1  read address handshake
araddr  in  ADDR_WIDTH  read start byte address
arlen  in  8  beats-1
arsize  in  3  bytes per beat (log2)
arburst  in  2  00 FIXED, 01 INCR, 10 treated as INCR
arid  in  ID_WIDTH  read transaction ID
arcache/arprot/arlock  in  4/3/2  accepted, ignored
rvalid/rready  out/in  1/1  read data handshake
rdata  out  AXI_DATA_WIDTH  read beat
rresp  out  2  00 OKAY, 10 SLVERR
rlast  out  1  final beat
rid  out  ID_WIDTH  = captured arid
awvalid/awready  in/out  1/1  write address handshake
awaddr  in  ADDR_WIDTH  write start byte address
awlen  in  8  beats-1
awsize  in  3  bytes per beat (log2)
awburst  in  2  same encoding as arburst
awid  in  ID_WIDTH  write transaction ID
awcache/awprot/awlock  in  4/3/2  accepted, ignored
wvalid/wready  in/out  1/1  write data handshake
wdata  in  AXI_DATA_WIDTH  write beat
wstrb  in  B  byte enables
wlast  in  1  final write beat
bvalid/bready  out/in  1/1  write response handshake
bresp  out  2  00 OKAY, 10 SLVERR
bid  out  ID_WIDTH  = captured awid

Behaviour:
- Reset: all outputs 0 while rst is high; rst asserted mid-burst aborts immediately and both FSMs go to IDLE. Memory contents are not reset.
- Word index = addr[log2(B)+log2(MEM_DEPTH)-1 : log2(B)]. Out of range when addr >= MEM_DEPTH*B.
- INCR advances the index by 1 per beat, wrapping mod MEM_DEPTH. FIXED holds the index. Size is checked only for the error rule below.
- Read FSM R_IDLE -> R_DATA:
  - R_IDLE: arready=1. On arvalid&&arready, capture addr/len/id/burst; beat counter = 0.
  - R_DATA: rvalid=1; first rvalid is in the cycle after the AR handshake. rdata = mem[index] (combinational read of the registered index). rlast = (counter==len). rid = captured id.
  - While rvalid&&!rready, rdata/rresp/rlast/rid hold stable.
  - On handshake with rlast=1 -> R_IDLE, and arready returns the next cycle. Otherwise counter++ and index advances.
  - rresp=SLVERR with rdata=0 for beats whose address is out of range, or for the whole burst when arsize != log2(B).
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1. On awvalid&&awready, capture addr/len/id/burst; counter = 0; err = 0.
  - W_DATA: wready=1. Each wvalid&&wready writes wdata bytes where wstrb=1 into mem[index] at that edge; the data is readable from the next cycle. Out-of-range beats are dropped and set err.
  - wlast on a beat with counter != len sets err and ends the burst.
  - counter reaching len without wlast: the beat is written, err is set, and the FSM stays in W_DATA until wlast.
  - awsize != log2(B) sets err.
  - After the wlast handshake -> W_RESP.
  - W_RESP: bvalid=1, bid = id, bresp = err ? SLVERR : OKAY. Held until bready; then -> W_IDLE.
- Read and write proceed concurrently. A read of a word in the same cycle as its write returns the old data.
- awready=0 outside W_IDLE; arready=0 outside R_IDLE. W data arriving before the AW handshake is not accepted (wready=0).

Test Plan:
- Single beat: write awaddr=0x100, wdata=0x0123..EF, wstrb=all-ones, id=3 -> bvalid, bid=3, bresp=00. Then read araddr=0x100 -> one beat, rdata=0x0123..EF, rlast=1, rid=3.
- INCR read arlen=7 from 0x0 after preloading words 0..7 = i, with rready toggled 1/0 -> 8 beats 0..7 in order, data held during stalls, rlast only on beat 8.
- Byte strobe: write 0xFFFF..F, then write wstrb=0x0001 wdata=0xAA -> read returns 0xFFFF..FFAA.
- Errors: araddr=MEM_DEPTH*B -> rresp=10, rdata=0. Write with awlen=3 but wlast on beat 2 -> bresp=10.
- Concurrency and reset: 4-beat read and 4-beat write overlapped on disjoint addresses -> both complete OKAY. Assert rst mid-read -> rvalid drops immediately; arready=1 on the first cycle after rst releases.
